// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute-to-writeback register stage behind the 8-bit ALU.
// Registers the ALU result and drives the register-file write port. Holds the
// architectural, saved-flag and output-port registers, and produces
// operand-forwarding hits for the decode stage.
module ex_wb_stage #(
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_ex,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       op_dec,
    input  logic [RA_W-1:0]  rd_dec,
    input  logic [7:0]       ans_tmp,
    input  logic [3:0]       flag_ex,
    input  logic [7:0]       data_out_buff,
    input  logic [RA_W-1:0]  rs_a,
    input  logic [RA_W-1:0]  rs_b,
    output logic [7:0]       ans_ex,
    output logic [3:0]       flag_reg,
    output logic [3:0]       flag_tmp,
    output logic [7:0]       data_out,
    output logic             out_strobe,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [7:0]       rf_wdata,
    output logic             valid_wb,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_SAVE = 5'b11000;

    // Opcodes that write a result back to the register file.
    function automatic logic is_write(input logic [4:0] op);
        logic w;
        w = 1'b0;
        case (op)
            5'b00000, 5'b00001, 5'b00010, 5'b00100,
            5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01100,
            5'b01101, 5'b01110, 5'b01111,
            5'b10100, 5'b10101, 5'b10110,
            5'b11001, 5'b11010, 5'b11011: w = 1'b1;
            default:                      w = 1'b0;
        endcase
        return w;
    endfunction

    // Opcodes that update the architectural flags: writers other than
    // 10100/10101, plus the 111xx flag-restore group.
    function automatic logic is_flag(input logic [4:0] op);
        return (is_write(op) && (op != 5'b10100) && (op != 5'b10101))
               || (op[4:2] == 3'b111);
    endfunction

    logic [7:0]       ans_q,    ans_d;
    logic [3:0]       flag_q,   flag_d;
    logic [3:0]       ftmp_q,   ftmp_d;
    logic [7:0]       dout_q,   dout_d;
    logic             strb_q,   strb_d;
    logic             we_q,     we_d;
    logic [RA_W-1:0]  waddr_q,  waddr_d;
    logic             vld_q,    vld_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // Next-state selection: flush beats stall, stall beats normal operation.
    always_comb begin
        ans_d   = ans_q;
        flag_d  = flag_q;
        ftmp_d  = ftmp_q;
        dout_d  = dout_q;
        strb_d  = 1'b0;
        we_d    = we_q;
        waddr_d = waddr_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        if (flush) begin
            vld_d = 1'b0;
            we_d  = 1'b0;
        end else if (stall) begin
            // Hold everything; the strobe must not repeat.
        end else if (valid_ex) begin
            ans_d   = ans_tmp;
            we_d    = is_write(op_dec);
            waddr_d = rd_dec;
            vld_d   = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (is_flag(op_dec))
                flag_d = flag_ex;
            if (op_dec == OP_SAVE)
                ftmp_d = flag_q;
            if (op_dec == OP_OUT) begin
                dout_d = data_out_buff;
                strb_d = 1'b1;
            end
        end else begin
            vld_d = 1'b0;
            we_d  = 1'b0;
        end
    end

    // Stage registers with synchronous reset that clears every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            ans_q   <= '0;
            flag_q  <= '0;
            ftmp_q  <= '0;
            dout_q  <= '0;
            strb_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ans_q   <= ans_d;
            flag_q  <= flag_d;
            ftmp_q  <= ftmp_d;
            dout_q  <= dout_d;
            strb_q  <= strb_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ans_ex     = ans_q;
    assign flag_reg   = flag_q;
    assign flag_tmp   = ftmp_q;
    assign data_out   = dout_q;
    assign out_strobe = strb_q;
    assign rf_we      = we_q;
    assign rf_waddr   = waddr_q;
    assign rf_wdata   = ans_q;
    assign valid_wb   = vld_q;
    assign retire_cnt = cnt_q;

    // Forwarding hits come only from registered state.
    assign fwd_a = vld_q & we_q & (waddr_q == rs_a);
    assign fwd_b = vld_q & we_q & (waddr_q == rs_b);

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_ex_wb_stage;

    localparam int RA_W  = 3;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, valid_ex, stall, flush;
    logic [4:0]       op_dec;
    logic [RA_W-1:0]  rd_dec, rs_a, rs_b;
    logic [7:0]       ans_tmp, data_out_buff;
    logic [3:0]       flag_ex;
    logic [7:0]       ans_ex, data_out, rf_wdata;
    logic [3:0]       flag_reg, flag_tmp;
    logic             out_strobe, rf_we, valid_wb, fwd_a, fwd_b;
    logic [RA_W-1:0]  rf_waddr;
    logic [CNT_W-1:0] retire_cnt;

    ex_wb_stage #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_ex(valid_ex), .stall(stall), .flush(flush),
        .op_dec(op_dec), .rd_dec(rd_dec), .ans_tmp(ans_tmp), .flag_ex(flag_ex),
        .data_out_buff(data_out_buff), .rs_a(rs_a), .rs_b(rs_b),
        .ans_ex(ans_ex), .flag_reg(flag_reg), .flag_tmp(flag_tmp),
        .data_out(data_out), .out_strobe(out_strobe), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .valid_wb(valid_wb),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .retire_cnt(retire_cnt)
    );

    int passed = 0;
    int total  = 0;

    // Opcode class membership tables, built from the listed opcode values.
    bit [31:0] wset, fset;

    // Behavioural model state
    logic [7:0]       m_ans, m_do;
    logic [3:0]       m_fr, m_ft;
    logic             m_strb, m_we, m_vwb;
    logic [RA_W-1:0]  m_wa;
    logic [CNT_W-1:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic s, input logic f,
                         input logic [4:0] op, input logic [RA_W-1:0] rd,
                         input logic [7:0] a, input logic [3:0] fl, input logic [7:0] db);
        rst = r; valid_ex = v; stall = s; flush = f;
        op_dec = op; rd_dec = rd; ans_tmp = a; flag_ex = fl; data_out_buff = db;
    endtask

    // Apply the stage rules to the model for one rising edge.
    task automatic model_edge();
        logic [3:0] old_fr;
        old_fr = m_fr;
        if (rst) begin
            m_ans = 0; m_fr = 0; m_ft = 0; m_do = 0; m_strb = 0;
            m_we = 0; m_wa = 0; m_vwb = 0; m_cnt = 0;
        end else if (flush || (!valid_ex && !stall)) begin
            m_vwb = 0; m_we = 0; m_strb = 0;
        end else if (stall) begin
            m_strb = 0;
        end else begin
            m_ans = ans_tmp;
            m_we  = wset[op_dec];
            m_wa  = rd_dec;
            m_vwb = 1;
            m_cnt = m_cnt + 1'b1;
            if (fset[op_dec]) m_fr = flag_ex;
            if (op_dec == 5'd24) m_ft = old_fr;
            m_strb = (op_dec == 5'd23);
            if (op_dec == 5'd23) m_do = data_out_buff;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ans"},   ans_ex,     m_ans);
        chk({tag, "_wdata"}, rf_wdata,   m_ans);
        chk({tag, "_flag"},  flag_reg,   m_fr);
        chk({tag, "_ftmp"},  flag_tmp,   m_ft);
        chk({tag, "_dout"},  data_out,   m_do);
        chk({tag, "_strb"},  out_strobe, m_strb);
        chk({tag, "_we"},    rf_we,      m_we);
        chk({tag, "_waddr"}, rf_waddr,   m_wa);
        chk({tag, "_vwb"},   valid_wb,   m_vwb);
        chk({tag, "_cnt"},   retire_cnt, m_cnt);
        chk({tag, "_fwda"},  fwd_a, m_vwb & m_we & (m_wa == rs_a));
        chk({tag, "_fwdb"},  fwd_b, m_vwb & m_we & (m_wa == rs_b));
    endtask

    initial begin
        int wl[20] = '{0,1,2,4,5,6,7,8,9,10,12,13,14,15,20,21,22,25,26,27};
        logic [7:0] held_ans;
        logic [CNT_W-1:0] held_cnt;
        wset = 0;
        foreach (wl[i]) wset[wl[i]] = 1'b1;
        fset = wset;
        fset[20] = 1'b0; fset[21] = 1'b0;
        for (int i = 28; i < 32; i++) fset[i] = 1'b1;
        m_ans = 'x; m_fr = 'x; m_ft = 'x; m_do = 'x; m_strb = 'x;
        m_we = 'x; m_wa = 'x; m_vwb = 'x; m_cnt = 'x;
        rs_a = 0; rs_b = 0;

        // Reset for two cycles with a valid instruction presented
        drive(1, 1, 0, 0, 5'd0, 3'd3, 8'h77, 4'hF, 8'h11);
        tick(); tick();
        check_all("reset");
        chk("reset_cnt_const", retire_cnt, 0);

        // Add retire with forwarding
        rs_a = 3'd5; rs_b = 3'd4;
        drive(0, 1, 0, 0, 5'd0, 3'd5, 8'h3C, 4'h0, 8'h00);
        tick();
        check_all("add");
        chk("add_we", rf_we, 1); chk("add_waddr", rf_waddr, 5);
        chk("add_wdata", rf_wdata, 8'h3C);
        chk("add_fwda", fwd_a, 1); chk("add_fwdb", fwd_b, 0);

        // Save / restore flags
        drive(0, 1, 0, 0, 5'b00001, 3'd1, 8'h10, 4'h2, 8'h00); tick();
        chk("sr_fr0", flag_reg, 4'h2);
        drive(0, 1, 0, 0, 5'b11000, 3'd1, 8'h11, 4'h9, 8'h00); tick();
        check_all("save");
        chk("save_ftmp", flag_tmp, 4'h2); chk("save_we", rf_we, 0);
        chk("save_fr", flag_reg, 4'h2);
        drive(0, 1, 0, 0, 5'b01000, 3'd2, 8'h12, 4'h8, 8'h00); tick();
        chk("sr_fr8", flag_reg, 4'h8);
        drive(0, 1, 0, 0, 5'b11100, 3'd2, 8'h13, 4'h2, 8'h00); tick();
        check_all("restore");
        chk("restore_fr", flag_reg, 4'h2); chk("restore_we", rf_we, 0);

        // Output port write then three stall cycles
        drive(0, 1, 0, 0, 5'b10111, 3'd0, 8'h20, 4'h0, 8'hA5); tick();
        chk("out_dout", data_out, 8'hA5); chk("out_strb", out_strobe, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 5'b10111, 3'd0, 8'h21, 4'h0, 8'h5A); tick();
            check_all("outstall");
            chk("outstall_strb", out_strobe, 0);
            chk("outstall_dout", data_out, 8'hA5);
        end

        // Stall holds a writer; stall+flush drains it
        rs_a = 3'd2; rs_b = 3'd6;
        drive(0, 1, 0, 0, 5'b00100, 3'd2, 8'h44, 4'h1, 8'h00); tick();
        held_ans = ans_ex; held_cnt = retire_cnt;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 5'b00000, 3'd6, 8'h99, 4'h4, 8'h00); tick();
            check_all("stall");
            chk("stall_we", rf_we, 1); chk("stall_fwda", fwd_a, 1);
        end
        drive(0, 1, 1, 1, 5'b00000, 3'd6, 8'h99, 4'h4, 8'h00); tick();
        check_all("flush");
        chk("flush_we", rf_we, 0); chk("flush_vwb", valid_wb, 0);
        chk("flush_ans", ans_ex, held_ans); chk("flush_cnt", retire_cnt, held_cnt);

        // Reset during stall overrides it
        drive(1, 1, 1, 0, 5'b00000, 3'd6, 8'h99, 4'h4, 8'h00); tick();
        check_all("rststall");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rs_a = RA_W'($urandom); rs_b = RA_W'($urandom);
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 9) < 1),
                  5'($urandom), RA_W'($urandom), 8'($urandom), 4'($urandom),
                  8'($urandom));
            tick();
            check_all("rand");
        end

        // Counter wrap
        drive(1, 0, 0, 0, 5'd0, 3'd0, 8'h00, 4'h0, 8'h00); tick();
        for (int i = 0; i < 65535; i++) begin
            drive(0, 1, 0, 0, 5'($urandom), RA_W'($urandom), 8'($urandom),
                  4'($urandom), 8'($urandom));
            tick();
        end
        check_all("preload");
        chk("preload_cnt", retire_cnt, 16'hFFFF);
        drive(0, 1, 0, 0, 5'd0, 3'd1, 8'h01, 4'h0, 8'h00); tick();
        check_all("wrap");
        chk("wrap_cnt", retire_cnt, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

Execute-to-writeback pipeline stage that sits directly downstream of the 8-bit ALU. It registers the ALU result and flags, and drives the register-file write port. It holds the architectural flag register, the saved-flag register and the output-port register. It feeds `ans_ex`, `flag_tmp` and `data_out` back to the ALU, and raises forwarding hits for the decode/operand stage.

## Interface
Parameters:
- `RA_W`, default 3: register-file address width (8 registers).
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_ex` in 1: the ALU holds a valid instruction this cycle.
- `stall` in 1: hold all stage state.
- `flush` in 1: squash the incoming instruction (insert a bubble).
- `op_dec` in 5: opcode of the instruction in the ALU.
- `rd_dec` in RA_W: destination register of that instruction.
- `ans_tmp` in 8: ALU result.
- `flag_ex` in 4: ALU flags {P, –, Z, –}, or the restored flags for ops 111xx.
- `data_out_buff` in 8: ALU output-port candidate.
- `rs_a` in RA_W: operand-A source register of the instruction in decode.
- `rs_b` in RA_W: operand-B source register of the instruction in decode.
- `ans_ex` out 8: registered result, fed back to the ALU.
- `flag_reg` out 4: architectural flags.
- `flag_tmp` out 4: saved flags, fed back to the ALU.
- `data_out` out 8: output-port register, fed back to the ALU.
- `out_strobe` out 1: one-cycle pulse when `data_out` is written.
- `rf_we` out 1: register-file write enable (registered).
- `rf_waddr` out RA_W: register-file write address (registered).
- `rf_wdata` out 8: register-file write data; equals `ans_ex`.
- `valid_wb` out 1: the stage holds a valid retired instruction.
- `fwd_a` out 1: combinational forwarding hit for `rs_a`.
- `fwd_b` out 1: combinational forwarding hit for `rs_b`.
- `retire_cnt` out CNT_W: count of retired instructions.

## Operation
Enable and priority:
- `accept` = `valid_ex & !stall & !flush`.
- Priority order: `rst` > `flush` > `stall` > normal.

Write class W (sets `rf_we` when accepted):
- 00000–00111 except 00011.
- 01000–01111 except 01011.
- 10100, 10101, 10110, 11001, 11010, 11011.
- All other opcodes never write the register file.

Flag class F (`flag_reg` <= `flag_ex` when accepted):
- Every opcode in W except 10100 and 10101.
- Opcodes 11100–11111 (flag restore).
- All other opcodes hold `flag_reg`.

Per-cycle behaviour when `accept`:
- `ans_ex` <= `ans_tmp` (every opcode).
- `rf_we` <= (op in W).
- `rf_waddr` <= `rd_dec`.
- `valid_wb` <= 1.
- `retire_cnt` <= `retire_cnt` + 1, wrapping from all-ones to 0.

Special opcodes, on accept:
- Op 11000: `flag_tmp` <= current `flag_reg`, i.e. the value before this edge. `flag_reg` itself is unchanged.
- Op 10111: `data_out` <= `data_out_buff`; `out_strobe` <= 1.

Flush and stall:
- `flush`, or `!valid_ex` without stall: `valid_wb`, `rf_we` and `out_strobe` are cleared to 0. `ans_ex`, `flag_reg`, `flag_tmp`, `data_out`, `rf_waddr` and `retire_cnt` hold.
- `stall` (no flush): every register holds, including `rf_we` and `valid_wb`. `out_strobe` is forced to 0 so a stalled cycle never repeats the strobe.

Forwarding:
- `fwd_a` = `valid_wb & rf_we & (rf_waddr == rs_a)`.
- `fwd_b` is defined the same way against `rs_b`.
- Forwarding is purely combinational from registered state.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on `ans_ex`, `rf_*`, `flag_reg` and `valid_wb` after edge N.
- The register file samples `rf_we`/`rf_waddr`/`rf_wdata` at edge N+1.
- `out_strobe` is high for exactly the cycle after the accepting edge.
- Reset (synchronous): all outputs are 0 after the first `rst` edge, including `ans_ex`, `flag_reg`, `flag_tmp`, `data_out`, `rf_we`, `rf_waddr`, `valid_wb`, `out_strobe` and `retire_cnt`. `fwd_a`/`fwd_b` are therefore 0.
- `rst` asserted mid-stall or mid-flush overrides both. An instruction presented in the reset cycle is discarded.
- Back-to-back 11000 then 11100: the save captures the pre-edge flags. The restore then sees the new `flag_tmp` one cycle later through the ALU, with no extra bubble.
- `stall` and `flush` high together: flush wins and the stage drains to a bubble.

## Test plan
- **Reset:** drive `rst` = 1 for 2 cycles with `valid_ex` = 1 and op 00000 -> all outputs 0, `retire_cnt` = 0.
- **Add retire:** op 00000, `ans_tmp` = 0x3C, `flag_ex` = 0x0, `rd_dec` = 5 -> next cycle `rf_we` = 1, `rf_waddr` = 5, `rf_wdata` = 0x3C. With `rs_a` = 5, `fwd_a` = 1; `rs_b` = 4 gives `fwd_b` = 0.
- **Save/restore:** op 00001 with `flag_ex` = 0x2, then op 11000, then op 11100 with `flag_ex` = 0x2 after 01000 changed flags to 0x8 -> `flag_tmp` = 0x2 after 11000, `flag_reg` = 0x2 after 11100, `rf_we` = 0 for 11000/11100.
- **Output port:** op 10111, `data_out_buff` = 0xA5 -> `data_out` = 0xA5, `out_strobe` a single 1-cycle pulse. Then `stall` for 3 cycles -> `data_out` holds, strobe stays 0.
- **Stall/flush:** accept op 00100 (`rd_dec` = 2), then `stall` = 1 for 2 cycles -> `rf_we` = 1 and `fwd` held. Then `stall` = `flush` = 1 -> `rf_we` = `valid_wb` = 0, `ans_ex` unchanged, `retire_cnt` unchanged.
- **Counter wrap:** preload via 65535 accepted ops -> `retire_cnt` = 0xFFFF, then one more accept -> 0x0000.
